// File: rtl/mvau_stream_acc_out_pkg.sv
// Shared MVAU definitions: parameterised accumulator lane type and sign-extension helper.
`define MVAU_ACC_LANE_T(W) logic signed [(W)-1:0]

package mvau_defn;

  localparam int SEXT_W = 64;

  // Sign-extend the low w bits of v to SEXT_W bits; callers truncate to their lane width.
  function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] v, input int w);
    logic signed [SEXT_W-1:0] t;
    t = $signed(v << (SEXT_W - w));
    return t >>> (SEXT_W - w);
  endfunction

endpackage

// File: rtl/mvau_stream_out_fifo.sv
// Generic synchronous FIFO, registered read head (rdata = oldest entry), storage cleared on reset.
// Push when full and pop when empty are ignored; pointers wrap naturally at power-of-two DEPTH.
module mvau_stream_out_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mvau_stream_acc_out.sv
// MVAU output stage: accumulates SF partial-sum beats per PE lane, queues finished vectors.
// Vector valid the cycle after the last beat is accepted; in_rdy drops only while the FIFO is full.
module mvau_stream_acc_out
  import mvau_defn::*;
#(
  parameter int PE    = 2,
  parameter int TSRC  = 16,
  parameter int TDST  = 24,
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_v,
  input  logic                 in_last,
  input  logic [PE*TSRC-1:0]   in_d,
  output logic                 in_rdy,
  output logic                 out_v,
  input  logic                 out_rdy,
  output logic [PE*TDST-1:0]   out_d
);

  typedef `MVAU_ACC_LANE_T(TDST) acc_lane_t;

  logic                    first_q;
  logic [PE*TDST-1:0]      acc_q;
  logic [PE*TDST-1:0]      sum_d;
  acc_lane_t               ext_l;
  acc_lane_t               sum_l;
  logic                    accept;
  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;

  assign in_rdy = ~fifo_full;
  assign out_v  = ~fifo_empty;
  assign accept = in_v & in_rdy;
  assign push   = accept & in_last;
  assign pop    = out_v & out_rdy;

  // First beat of a fold loads the lane directly so stale acc_q never leaks into a new fold.
  always_comb begin
    sum_d = '0;
    ext_l = '0;
    sum_l = '0;
    for (int p = 0; p < PE; p++) begin
      ext_l = TDST'(sext(SEXT_W'(in_d[p*TSRC +: TSRC]), TSRC));
      sum_l = first_q ? ext_l : acc_lane_t'(acc_q[p*TDST +: TDST]) + ext_l;
      sum_d[p*TDST +: TDST] = sum_l;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= 1'b1;
      acc_q   <= '0;
    end else if (accept) begin
      if (in_last) begin
        first_q <= 1'b1;
      end else begin
        first_q <= 1'b0;
        acc_q   <= sum_d;
      end
    end
  end

  mvau_stream_out_fifo #(
    .WIDTH (PE*TDST),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (sum_d),
    .rdata (out_d),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_mvau_stream_acc_out.sv
// Bench for mvau_stream_acc_out: directed fold cases plus randomized traffic against a fold-sum model.
module tb_mvau_stream_acc_out;

  localparam int PE = 2, TSRC = 16, TDST = 24, DEPTH = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_v, in_last, in_rdy, out_v, out_rdy;
  logic [PE*TSRC-1:0]  in_d;
  logic [PE*TDST-1:0]  out_d;

  logic                w_v, w_last, w_rdy, w_out_v, w_out_rdy;
  logic [7:0]          w_d, w_out_d;

  int n_vec = 0, n_bad = 0;
  int push_cnt = 0, pop_cnt = 0;
  bit acc_seen, rand_rdy = 0;

  logic [PE*TDST-1:0] exp_q [$];
  longint             fold_acc [PE];
  int                 fold_n = 0;

  always #5 clk = ~clk;

  mvau_stream_acc_out #(.PE(PE), .TSRC(TSRC), .TDST(TDST), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_v(in_v), .in_last(in_last), .in_d(in_d), .in_rdy(in_rdy),
    .out_v(out_v), .out_rdy(out_rdy), .out_d(out_d));

  mvau_stream_acc_out #(.PE(1), .TSRC(8), .TDST(8), .DEPTH(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_v(w_v), .in_last(w_last), .in_d(w_d), .in_rdy(w_rdy),
    .out_v(w_out_v), .out_rdy(w_out_rdy), .out_d(w_out_d));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int a0, input int a1);
    return {16'(a1), 16'(a0)};
  endfunction

  // Reference: each fold's vector is the plain integer sum of its beats, reduced mod 2^TDST.
  task automatic monitor();
    logic [PE*TDST-1:0] v;
    longint             s;
    acc_seen = 0;
    if (!rst_n) return;
    chk("out_v", out_v, exp_q.size() != 0);
    chk("in_rdy", in_rdy, exp_q.size() < DEPTH);
    if (out_v && exp_q.size() != 0) chk("out_d", out_d, exp_q[0]);
    if (out_v && out_rdy) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      pop_cnt++;
    end
    if (in_v && in_rdy) begin
      acc_seen = 1;
      v = '0;
      for (int p = 0; p < PE; p++) begin
        s = longint'($signed(in_d[p*TSRC +: TSRC]));
        fold_acc[p] = (fold_n == 0) ? s : fold_acc[p] + s;
        v[p*TDST +: TDST] = fold_acc[p][TDST-1:0];
      end
      if (in_last) begin
        exp_q.push_back(v);
        push_cnt++;
        fold_n = 0;
      end else begin
        fold_n++;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input logic [31:0] d, input bit last);
    int k = 0;
    in_v = 1'b1; in_d = d; in_last = last;
    do begin
      cycle();
      k++;
    end while (!acc_seen && k < 200);
    if (!acc_seen) chk("accept_timeout", 0, 1);
    in_v = 1'b0;
  endtask

  initial begin
    int p0, s0, k, sf;
    rst_n = 1'b0; in_v = 0; in_last = 0; in_d = '0; out_rdy = 1'b1;
    w_v = 0; w_last = 0; w_d = '0; w_out_rdy = 1'b1;
    #12;
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_out_v", out_v, 0);
    chk("rst_out_d", out_d, 0);
    chk("rst_w_out_v", w_out_v, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Four-beat fold, lane0 1..4, lane1 -1 each
    for (int i = 1; i <= 4; i++) send_beat(pk(i, -1), i == 4);
    chk("t1_out_v", out_v, 1);
    chk("t1_out_d", out_d, {24'hFFFFFC, 24'd10});
    cycle();

    // SF=1 sign extension at both extremes, back to back
    send_beat(pk(16'h7FFF, 16'h7FFF), 1);
    chk("t2_pos", out_d, {24'h007FFF, 24'h007FFF});
    send_beat(pk(16'h8000, 16'h8000), 1);
    chk("t2_neg", out_d, {24'hFF8000, 24'hFF8000});
    cycle();
    cycle();

    // Backpressure: two folds fill the FIFO, third is held, then drain in order
    out_rdy = 1'b0;
    send_beat(pk(3, 7), 0);  send_beat(pk(3, 7), 1);
    chk("t3_rdy_after1", in_rdy, 1);
    send_beat(pk(-5, 1), 0); send_beat(pk(-5, 1), 1);
    chk("t3_rdy_full", in_rdy, 0);
    in_v = 1'b1; in_d = pk(9, 9); in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3_held", acc_seen, 0);
      chk("t3_stable", out_d, {24'd14, 24'd6});
    end
    out_rdy = 1'b1;
    send_beat(pk(9, 9), 0); send_beat(pk(9, 9), 1);
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin cycle(); k++; end
    cycle();
    chk("t3_drained", out_v, 0);

    // 8-bit accumulator wraps instead of saturating: 4 x 100 = 144 mod 256
    chk("t4_rdy", w_rdy, 1);
    for (int i = 0; i < 4; i++) begin
      w_v = 1'b1; w_d = 8'd100; w_last = (i == 3);
      cycle();
    end
    w_v = 1'b0; w_last = 1'b0;
    chk("t4_out_v", w_out_v, 1);
    chk("t4_wrap", w_out_d, 8'd144);
    cycle();
    chk("t4_popped", w_out_v, 0);

    // Reset mid-fold with one vector queued
    out_rdy = 1'b0;
    send_beat(pk(2, 2), 0); send_beat(pk(2, 2), 1);
    send_beat(pk(1, 1), 0); send_beat(pk(1, 1), 0);
    chk("t5_pre_out_v", out_v, 1);
    rst_n = 1'b0;
    exp_q.delete(); fold_n = 0;
    #1;
    chk("t5_out_v", out_v, 0);
    chk("t5_in_rdy", in_rdy, 1);
    chk("t5_out_d", out_d, 0);
    #1 rst_n = 1'b1;
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(pk(1, 1), i == 3);
    chk("t5_fold", out_d, {24'd4, 24'd4});
    cycle();

    // Random traffic: 1000 folds with random SF, idle gaps and out_rdy toggling
    p0 = pop_cnt; s0 = push_cnt;
    rand_rdy = 1;
    for (int f = 0; f < 1000; f++) begin
      sf = $urandom_range(1, 4);
      for (int b = 0; b < sf; b++) begin
        k = $urandom_range(0, 2);
        for (int g = 0; g < k; g++) cycle();
        send_beat($urandom, b == sf - 1);
      end
    end
    rand_rdy = 0;
    out_rdy = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin cycle(); k++; end
    cycle();
    chk("rand_pushed", push_cnt - s0, 1000);
    chk("rand_popped", pop_cnt - p0, 1000);
    chk("rand_empty", out_v, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mvau_stream_acc_out.md
# mvau_stream_acc_out

Downstream output stage of the MVAU streaming block. It accumulates per-PE SIMD partial sums over SF input beats to form one output vector per weight-matrix row fold. Completed PE-wide vectors are buffered in a small FIFO and presented on an AXI-stream-style valid/ready output. It also generates the upstream stall signal that halts the streaming control counters when the output side back-pressures.

## Interface

Parameters:
- PE, 2: processing elements, i.e. output lanes per vector
- TSRC, 16: signed partial-sum width per PE from the SIMD adder tree
- TDST, 24: signed accumulator/output width per lane, TDST ≥ TSRC
- DEPTH, 2: output FIFO depth in vectors, power of two, ≥ 2

Ports:
- clk, input, 1, main clock
- rst_n, input, 1, reset; asynchronous assert, active-low
- in_v, input, 1, partial-sum beat valid (qualified do_mvau_stream)
- in_last, input, 1, beat is the SF-th (final) of the current fold (aligned sf_clr)
- in_d, input, PE*TSRC, packed signed partial sums; lane p at [p*TSRC +: TSRC]
- in_rdy, output, 1, beat accepted when in_v & in_rdy; upstream holds in_d/in_last while low
- out_v, output, 1, output vector valid
- out_rdy, input, 1, downstream ready
- out_d, output, PE*TDST, packed signed accumulated vector; lane p at [p*TDST +: TDST]

## Operation

- Accept = in_v & in_rdy. No state changes on unaccepted beats.
- first_q flag: 1 out of reset and after an accepted last beat. Cleared by an accepted non-last beat.
- Per lane: sum = first_q ? sext(in_d[p]) : acc_q[p] + sext(in_d[p]), modulo 2^TDST (wrap, no saturation).
- Accepted non-last beat: acc_q ← sum.
- Accepted last beat: sum is pushed into the FIFO, and acc_q is don't-care.
- SF=1 operation: every beat has in_last=1 and first_q stays 1, so each beat is pushed unmodified (sign-extended).
- in_rdy = (count < DEPTH). It is a registered-state function only, with no combinational path from out_rdy.
- Simultaneous push and pop with the FIFO full cannot occur, because in_rdy=0. Simultaneous push and pop otherwise leaves count unchanged.
- Pop = out_v & out_rdy. out_v = (count ≠ 0). out_d = head entry, stable while out_v & !out_rdy.
- Reset mid-fold discards the partial accumulation and all FIFO contents.

## Timing

- Reset values: in_rdy=1, out_v=0, out_d=0 (FIFO storage cleared), first_q=1, count=0, acc_q=0.
- Latency: a last beat accepted at edge N gives out_v=1 from edge N (visible in cycle N+1) if the FIFO was empty.
- Throughput: one beat per cycle while out_rdy=1. DEPTH vectors are absorbed while out_rdy=0.
- in_rdy falls in the cycle after the push that fills the FIFO. It rises in the cycle after the first pop.
- Wrap-around: FIFO read and write pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.

## Structure

- Shared package mvau_defn gains:
  - acc_lane_t, logic signed [TDST-1:0] via parameterised typedef/macro
  - the sign-extension helper function
- Sub-module mvau_stream_out_fifo, a generic synchronous FIFO with parameters WIDTH and DEPTH and ports push, pop, wdata, rdata, count, full, empty.
  - It is instantiated once with WIDTH=PE*TDST.
  - The accumulator datapath and first_q logic stay in the top.

## Test plan

- PE=2, SF=4, out_rdy=1, lane0 beats 1,2,3,4 and lane1 beats −1,−1,−1,−1 → one vector {10,−4} with out_v high exactly one cycle after the 4th accept.
- SF=1 (in_last always 1), lane values 0x7FFF then 0x8000 at TSRC=16, TDST=24 → outputs 0x007FFF then 0xFF8000 on consecutive cycles.
- DEPTH=2, out_rdy=0, three folds offered → two vectors held, in_rdy=0 after the 2nd push, and the 3rd fold's last beat is held. Raising out_rdy drains all three in order, with out_d stable while stalled.
- TDST=TSRC=8, 4-beat fold of 100 each → output 400 mod 256 = 144 (wrap, no saturation).
- Assert rst_n low mid-fold, with 2 of 4 beats accepted and one vector in the FIFO → out_v=0, in_rdy=1 immediately. The next 4-beat fold of 1s yields exactly 4.
- Random in_v/out_rdy toggling over 1000 folds → scoreboard match of every vector, with no drop and no duplicate.
